// File: rtl/axi4_slave_mem.sv
// AXI4 slave memory with independent write and read burst engines over a byte-writable word array.
// Optional macro AXI_SLV_BACKPRESSURE_EN adds LFSR-driven ready masking and read-valid delay.

module axi4_slave_mem #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_LEN_WIDTH  = 8,
    parameter int MEM_WORDS      = 256,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [AXI_ID_WIDTH-1:0]     awid,
    input  logic [AXI_ADDR_WIDTH-1:0]   awaddr,
    input  logic [AXI_LEN_WIDTH-1:0]    awlen,
    input  logic [2:0]                  awsize,
    input  logic [1:0]                  awburst,
    input  logic                        awvalid,
    output logic                        awready,
    input  logic [AXI_DATA_WIDTH-1:0]   wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] wstrb,
    input  logic                        wlast,
    input  logic                        wvalid,
    output logic                        wready,
    output logic [AXI_ID_WIDTH-1:0]     bid,
    output logic [1:0]                  bresp,
    output logic                        bvalid,
    input  logic                        bready,
    input  logic [AXI_ID_WIDTH-1:0]     arid,
    input  logic [AXI_ADDR_WIDTH-1:0]   araddr,
    input  logic [AXI_LEN_WIDTH-1:0]    arlen,
    input  logic [2:0]                  arsize,
    input  logic [1:0]                  arburst,
    input  logic                        arvalid,
    output logic                        arready,
    output logic [AXI_ID_WIDTH-1:0]     rid,
    output logic [AXI_DATA_WIDTH-1:0]   rdata,
    output logic [1:0]                  rresp,
    output logic                        rlast,
    output logic                        rvalid,
    input  logic                        rready
);

    localparam int STRB_W  = AXI_DATA_WIDTH / 8;
    localparam int BYTE_SH = $clog2(STRB_W);
    localparam int IDX_W   = $clog2(MEM_WORDS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];

    function automatic logic [AXI_ADDR_WIDTH-1:0] word_off(input logic [AXI_ADDR_WIDTH-1:0] addr);
        return (addr - BASE_ADDR) >> BYTE_SH;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [AXI_ADDR_WIDTH-1:0] addr);
        logic [AXI_ADDR_WIDTH-1:0] off;
        off = word_off(addr);
        return off[IDX_W-1:0];
    endfunction

    function automatic logic burst_bad(input logic [AXI_LEN_WIDTH-1:0] len,
                                       input logic [2:0] size, input logic [1:0] burst);
        logic wrap_len_ok;
        wrap_len_ok = (len == AXI_LEN_WIDTH'(1)) || (len == AXI_LEN_WIDTH'(3)) ||
                      (len == AXI_LEN_WIDTH'(7)) || (len == AXI_LEN_WIDTH'(15));
        return (int'(size) > BYTE_SH) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_len_ok);
    endfunction

    // Out-of-range outranks a malformed burst so the beat reports DECERR.
    function automatic logic [1:0] beat_resp(input logic [AXI_ADDR_WIDTH-1:0] addr,
                                             input logic [AXI_LEN_WIDTH-1:0] len,
                                             input logic [2:0] size, input logic [1:0] burst);
        if (word_off(addr) >= AXI_ADDR_WIDTH'(MEM_WORDS)) return RESP_DECERR;
        if (burst_bad(len, size, burst)) return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [AXI_ADDR_WIDTH-1:0] next_addr(input logic [AXI_ADDR_WIDTH-1:0] addr,
                                                            input logic [AXI_LEN_WIDTH-1:0] len,
                                                            input logic [2:0] size,
                                                            input logic [1:0] burst);
        logic [AXI_ADDR_WIDTH-1:0] nb, incr, wlen, wbase;
        nb    = AXI_ADDR_WIDTH'(1) << size;
        incr  = (addr & ~(nb - AXI_ADDR_WIDTH'(1))) + nb;
        wlen  = (AXI_ADDR_WIDTH'(len) + AXI_ADDR_WIDTH'(1)) << size;
        wbase = addr & ~(wlen - AXI_ADDR_WIDTH'(1));
        case (burst)
            2'b00:   return addr;
            2'b10:   return (incr == wbase + wlen) ? wbase : incr;
            default: return incr;
        endcase
    endfunction

    logic run_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) run_q <= 1'b0;
        else     run_q <= 1'b1;
    end

    // ---------------- write path ----------------
    w_state_t w_state, w_state_nxt;
    logic [AXI_ID_WIDTH-1:0]   w_id;
    logic [AXI_ADDR_WIDTH-1:0] w_addr;
    logic [AXI_LEN_WIDTH-1:0]  w_len, w_cnt;
    logic [2:0]                w_size;
    logic [1:0]                w_burst, w_resp, w_beat_resp;
    logic aw_rdy, w_rdy, aw_hs, w_hs, w_last_beat;

    assign aw_hs       = awvalid && awready;
    assign w_hs        = wvalid && wready;
    assign w_last_beat = (w_cnt == w_len);
    assign w_beat_resp = resp_max(beat_resp(w_addr, w_len, w_size, w_burst),
                                  (wlast != w_last_beat) ? RESP_SLVERR : RESP_OKAY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = w_state;
        aw_rdy      = 1'b0;
        w_rdy       = 1'b0;
        bvalid      = 1'b0;
        case (w_state)
            W_IDLE: begin
                aw_rdy = run_q;
                if (aw_hs) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                w_rdy = 1'b1;
                if (w_hs && w_last_beat) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (aw_hs) begin
            w_id    <= awid;
            w_addr  <= awaddr;
            w_len   <= awlen;
            w_size  <= awsize;
            w_burst <= awburst;
            w_cnt   <= '0;
            w_resp  <= RESP_OKAY;
        end else if (w_hs) begin
            w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
            w_cnt  <= w_cnt + AXI_LEN_WIDTH'(1);
            w_resp <= resp_max(w_resp, w_beat_resp);
        end
    end

    always_ff @(posedge clk) begin
        if (w_hs && w_beat_resp == RESP_OKAY) begin
            for (int b = 0; b < STRB_W; b++)
                if (wstrb[b]) mem[word_idx(w_addr)][b*8 +: 8] <= wdata[b*8 +: 8];
        end
    end

    assign bid   = bvalid ? w_id : '0;
    assign bresp = bvalid ? w_resp : RESP_OKAY;

    // ---------------- read path ----------------
    r_state_t r_state, r_state_nxt;
    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_ADDR_WIDTH-1:0] r_addr, r_addr_nxt, r_ld_addr;
    logic [AXI_LEN_WIDTH-1:0]  r_len, r_cnt, r_ld_len;
    logic [2:0]                r_size, r_ld_size;
    logic [1:0]                r_burst, r_ld_burst, r_ld_resp, r_resp_q;
    logic [AXI_DATA_WIDTH-1:0] r_ld_data, r_data_q;
    logic ar_rdy, r_busy, ar_hs, r_hs, r_last_beat, r_load;

    assign ar_hs       = arvalid && arready;
    assign r_hs        = rvalid && rready;
    assign r_last_beat = (r_cnt == r_len);
    assign r_addr_nxt  = next_addr(r_addr, r_len, r_size, r_burst);
    assign r_load      = ar_hs || (r_hs && !r_last_beat);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_state_nxt;
    end

    always_comb begin
        r_state_nxt = r_state;
        ar_rdy      = 1'b0;
        r_busy      = 1'b0;
        case (r_state)
            R_IDLE: begin
                ar_rdy = run_q;
                if (ar_hs) r_state_nxt = R_DATA;
            end
            R_DATA: begin
                r_busy = 1'b1;
                if (r_hs && r_last_beat) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // The beat is fetched into a register so rdata holds under stall and a
    // same-cycle write to that word is seen only by later beats.
    always_comb begin
        r_ld_addr  = r_addr_nxt;
        r_ld_len   = r_len;
        r_ld_size  = r_size;
        r_ld_burst = r_burst;
        if (r_state == R_IDLE) begin
            r_ld_addr  = araddr;
            r_ld_len   = arlen;
            r_ld_size  = arsize;
            r_ld_burst = arburst;
        end
        r_ld_resp = beat_resp(r_ld_addr, r_ld_len, r_ld_size, r_ld_burst);
        r_ld_data = (r_ld_resp == RESP_OKAY) ? mem[word_idx(r_ld_addr)] : '0;
    end

    always_ff @(posedge clk) begin
        if (ar_hs) begin
            r_id    <= arid;
            r_addr  <= araddr;
            r_len   <= arlen;
            r_size  <= arsize;
            r_burst <= arburst;
            r_cnt   <= '0;
        end else if (r_hs && !r_last_beat) begin
            r_addr <= r_addr_nxt;
            r_cnt  <= r_cnt + AXI_LEN_WIDTH'(1);
        end
        if (r_load) begin
            r_data_q <= r_ld_data;
            r_resp_q <= r_ld_resp;
        end
    end

`ifdef AXI_SLV_BACKPRESSURE_EN
    logic [15:0] lfsr;
    logic [1:0]  r_dly;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr <= 16'hACE1;
        else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              r_dly <= 2'd0;
        else if (r_load)      r_dly <= lfsr[1:0];
        else if (r_dly != 0)  r_dly <= r_dly - 2'd1;
    end

    assign awready = aw_rdy & lfsr[0];
    assign wready  = w_rdy  & lfsr[11];
    assign arready = ar_rdy & lfsr[7];
    assign rvalid  = r_busy && (r_dly == 2'd0);
`else
    assign awready = aw_rdy;
    assign wready  = w_rdy;
    assign arready = ar_rdy;
    assign rvalid  = r_busy;
`endif

    assign rid   = rvalid ? r_id : '0;
    assign rdata = rvalid ? r_data_q : '0;
    assign rresp = rvalid ? r_resp_q : RESP_OKAY;
    assign rlast = rvalid && r_last_beat;

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Scoreboard bench for axi4_slave_mem: stimulus pushes expected B/R responses, a monitor pops on handshakes.

module tb_axi4_slave_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr;
    logic [7:0]  awlen, arlen, wstrb;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [63:0] wdata, rdata;

    always #5 clk = ~clk;

    axi4_slave_mem dut (
        .clk(clk), .rst(rst),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    typedef struct packed { logic [3:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct packed { logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last; } r_exp_t;

    b_exp_t exp_b[$];
    r_exp_t exp_r[$];
    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [127:0] all_outputs();
        return {awready, wready, bvalid, bresp, bid, arready, rvalid, rid, rdata, rresp, rlast};
    endfunction

    // Scoreboard monitor: a handshake completes at the posedge following this sample.
    always @(negedge clk) begin
        b_exp_t eb;
        r_exp_t er;
        if (!rst && bvalid && bready) begin
            checks++;
            if (exp_b.size() == 0) begin
                failures++;
                $display("FAIL b_unexpected actual bid=%0h bresp=%0h required none", bid, bresp);
            end else begin
                checks--;
                eb = exp_b.pop_front();
                check("b_resp", {bid, bresp}, {eb.id, eb.resp});
            end
        end
        if (!rst && rvalid && rready) begin
            checks++;
            if (exp_r.size() == 0) begin
                failures++;
                $display("FAIL r_unexpected actual rdata=%0h required none", rdata);
            end else begin
                checks--;
                er = exp_r.pop_front();
                check("r_beat", {rid, rdata, rresp, rlast}, {er.id, er.data, er.resp, er.last});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // sel: 0 awready, 1 wready, 2 B handshake, 3 arready, 4 R handshake, 5 bvalid, 6 rvalid
    task automatic wait_hs(input string name, input int sel);
        logic hs;
        int n;
        n = 0;
        do begin
            @(negedge clk);
            case (sel)
                0: hs = awready;
                1: hs = wready;
                2: hs = bvalid && bready;
                3: hs = arready;
                4: hs = rvalid && rready;
                5: hs = bvalid;
                default: hs = rvalid;
            endcase
            tick();
            n++;
        end while (!hs && n < 200);
        check(name, hs, 1'b1);
    endtask

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [63:0] d0, input logic [63:0] d1,
                             input logic [63:0] d2, input logic [63:0] d3, input logic [7:0] s1,
                             input logic [1:0] resp, input int bhold);
        b_exp_t eb;
        eb.id = id;
        eb.resp = resp;
        exp_b.push_back(eb);
        awid = id; awaddr = addr; awlen = len; awsize = 3'd3; awburst = burst; awvalid = 1'b1;
        wait_hs("aw_hs", 0);
        awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            case (b)
                0: wdata = d0;
                1: wdata = d1;
                2: wdata = d2;
                default: wdata = d3;
            endcase
            wstrb  = (b == 1) ? s1 : 8'hFF;
            wlast  = (b == int'(len));
            wvalid = 1'b1;
            wait_hs("w_hs", 1);
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        if (bhold > 0) begin
            wait_hs("b_valid", 5);
            for (int h = 0; h < bhold; h++) begin
                @(negedge clk);
                check("b_hold", {bvalid, bresp, bid}, {1'b1, resp, id});
                tick();
            end
        end
        bready = 1'b1;
        wait_hs("b_hs", 2);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [63:0] e0, input logic [63:0] e1,
                            input logic [63:0] e2, input logic [63:0] e3, input logic [1:0] resp,
                            input int stall_beat, input int stall_cyc);
        r_exp_t er;
        logic [63:0] e;
        for (int b = 0; b <= int'(len); b++) begin
            case (b)
                0: e = e0;
                1: e = e1;
                2: e = e2;
                default: e = e3;
            endcase
            er.id = id; er.data = e; er.resp = resp; er.last = (b == int'(len));
            exp_r.push_back(er);
        end
        arid = id; araddr = addr; arlen = len; arsize = 3'd3; arburst = burst; arvalid = 1'b1;
        wait_hs("ar_hs", 3);
        arvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            if (b == stall_beat) begin
                case (b)
                    0: e = e0;
                    1: e = e1;
                    2: e = e2;
                    default: e = e3;
                endcase
                rready = 1'b0;
                wait_hs("r_valid", 6);
                for (int h = 0; h < stall_cyc; h++) begin
                    @(negedge clk);
                    check("r_hold", {rvalid, rdata, rlast}, {1'b1, e, 1'(b == int'(len))});
                    tick();
                end
            end
            rready = 1'b1;
            wait_hs("r_hs", 4);
        end
        rready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", all_outputs(), '0);
        tick();
        rst = 1'b0;
        #1;
        check("ready_before_edge", {awready, arready}, 2'b00);
        tick();
        check("ready_after_release", {awready, arready}, 2'b11);

        // Reset in W_DATA after two of four beats
        awid = 4'h9; awaddr = 32'h40; awlen = 8'd3; awsize = 3'd3; awburst = INCR; awvalid = 1'b1;
        wait_hs("aw_hs", 0);
        awvalid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            wdata = 64'h7700_0000_0000_0000 | 64'(b); wstrb = 8'hFF; wvalid = 1'b1;
            wait_hs("w_hs", 1);
        end
        wdata = 64'h7700_0000_0000_0002;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_outputs", all_outputs(), '0);
        wvalid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("awready_before_edge", awready, 1'b0);
        tick();
        check("awready_after_release", awready, 1'b1);

        // Single beat write and readback
        axi_write(4'h1, 32'h10, 8'd0, INCR, 64'hDEADBEEF_CAFEF00D, '0, '0, '0, 8'hFF, 2'b00, 0);
        axi_read(4'h2, 32'h10, 8'd0, INCR, 64'hDEADBEEF_CAFEF00D, '0, '0, '0, 2'b00, -1, 0);

        // INCR4 fill, then INCR4 with beat 1 lower-half strobe and B held off
        axi_write(4'h3, 32'h00, 8'd3, INCR, 64'h1000_0001_1000_0000, 64'h1000_0011_1000_0010,
                  64'h1000_0021_1000_0020, 64'h1000_0031_1000_0030, 8'hFF, 2'b00, 0);
        axi_write(4'h4, 32'h00, 8'd3, INCR, 64'h2000_0001_2000_0000, 64'h2000_0011_2000_0010,
                  64'h2000_0021_2000_0020, 64'h2000_0031_2000_0030, 8'h0F, 2'b00, 5);
        axi_read(4'h5, 32'h00, 8'd3, INCR, 64'h2000_0001_2000_0000, 64'h1000_0011_2000_0010,
                 64'h2000_0021_2000_0020, 64'h2000_0031_2000_0030, 2'b00, 2, 4);

        // WRAP4 from word 3 returns 3,0,1,2
        axi_read(4'h6, 32'h18, 8'd3, WRAP, 64'h2000_0031_2000_0030, 64'h2000_0001_2000_0000,
                 64'h1000_0011_2000_0010, 64'h2000_0021_2000_0020, 2'b00, -1, 0);

        // Out of range: DECERR, word 0 untouched
        axi_write(4'h7, 32'h800, 8'd0, INCR, 64'h5555_5555_5555_5555, '0, '0, '0, 8'hFF, 2'b11, 0);
        axi_read(4'h8, 32'h00, 8'd0, INCR, 64'h2000_0001_2000_0000, '0, '0, '0, 2'b00, -1, 0);
        axi_read(4'h9, 32'h800, 8'd0, INCR, '0, '0, '0, '0, 2'b11, -1, 0);

        // Reserved burst type: SLVERR, no write
        axi_write(4'hA, 32'h08, 8'd0, 2'b11, 64'h6666_6666_6666_6666, '0, '0, '0, 8'hFF, 2'b10, 0);
        axi_read(4'hB, 32'h08, 8'd0, INCR, 64'h1000_0011_2000_0010, '0, '0, '0, 2'b00, -1, 0);

        // FIXED read repeats the same word
        axi_read(4'hC, 32'h10, 8'd1, FIXED, 64'h2000_0021_2000_0020, 64'h2000_0021_2000_0020,
                 '0, '0, 2'b00, -1, 0);

        repeat (5) tick();
        check("b_queue_drained", 32'(exp_b.size()), 32'd0);
        check("r_queue_drained", 32'(exp_r.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
